// File: rtl/fetch_request_unit_pkg.sv
// Shared fetch definitions: default widths, buffer depth and the queue entry type.
package fetch_request_unit_pkg;

  localparam int FETCH_ADDR_W    = 32;
  localparam int FETCH_INSTR_W   = 32;
  localparam int FETCH_BUF_DEPTH = 4;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_sync_fifo.sv
// Synchronous FIFO with clear; push is allowed while full if a pop happens the same cycle.
module fetch_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (cnt_q != '0);
    do_push  = push_i && ((cnt_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is not reset; the head is only meaningful while count is non-zero.
  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_request_unit.sv
// Instruction fetch request unit: PC -> imem request register -> in-order response queues -> decode.
// Optional FETCH_STATS_EN adds delivered/discarded instruction counters.
module fetch_request_unit
  import fetch_request_unit_pkg::*;
#(
  parameter int ADDR_WIDTH  = FETCH_ADDR_W,
  parameter int INSTR_WIDTH = FETCH_INSTR_W,
  parameter int BUF_DEPTH   = FETCH_BUF_DEPTH
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   pc_valid_i,
  output logic                   pc_ready_o,
  input  logic [ADDR_WIDTH-1:0]  pc_addr_i,
  input  logic                   flush_i,
  output logic                   imem_req_valid_o,
  input  logic                   imem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]  imem_req_addr_o,
  input  logic                   imem_rsp_valid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data_i,
  output logic                   instr_valid_o,
  input  logic                   instr_ready_i,
  output logic [INSTR_WIDTH-1:0] instr_data_o,
  output logic [ADDR_WIDTH-1:0]  instr_pc_o
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]            stat_fetch_count_o,
  output logic [31:0]            stat_drop_count_o
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_OW = OW'(BUF_DEPTH);

  logic                  req_pending_q, req_pending_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [CW-1:0]         in_flight_q, in_flight_d;
  logic [CW-1:0]         drop_q, drop_d;

  logic [INSTR_WIDTH-1:0] data_head;
  logic [ADDR_WIDTH-1:0]  pc_head;
  logic [CW-1:0]          data_cnt, pc_cnt;
  logic [OW-1:0]          occ;
  logic                   pc_fire, imem_fire, dec_fire, rsp_drop, data_push;

  // Occupancy uses registered counts only, so freed slots show up one cycle later.
  assign occ = OW'(req_pending_q) + OW'(in_flight_q) + OW'(data_cnt) + OW'(drop_q);

  assign pc_ready_o = !reset_i && !flush_i && (!req_pending_q || imem_req_ready_i)
                      && (occ < DEPTH_OW);
  assign pc_fire    = pc_valid_i && pc_ready_o;
  assign imem_fire  = req_pending_q && imem_req_ready_i;
  assign dec_fire   = instr_valid_o && instr_ready_i;
  assign rsp_drop   = imem_rsp_valid_i && (drop_q != '0);
  assign data_push  = imem_rsp_valid_i && (drop_q == '0);

  assign imem_req_valid_o = req_pending_q;
  assign imem_req_addr_o  = req_addr_q;

  always_comb begin
    req_pending_d = req_pending_q;
    req_addr_d    = req_addr_q;
    if (imem_fire) req_pending_d = 1'b0;
    if (pc_fire) begin
      req_pending_d = 1'b1;
      req_addr_d    = pc_addr_i;
    end
  end

  // On flush every outstanding request (issued or still held) will return a
  // response that must be thrown away; a response landing this cycle is already consumed.
  always_comb begin
    in_flight_d = in_flight_q + CW'(imem_fire) - CW'(imem_rsp_valid_i);
    drop_d      = drop_q;
    if (flush_i)
      drop_d = in_flight_q + CW'(req_pending_q) - CW'(imem_rsp_valid_i);
    else if (rsp_drop)
      drop_d = drop_q - CW'(1);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      req_pending_q <= 1'b0;
      req_addr_q    <= '0;
      in_flight_q   <= '0;
      drop_q        <= '0;
    end else begin
      req_pending_q <= req_pending_d;
      req_addr_q    <= req_addr_d;
      in_flight_q   <= in_flight_d;
      drop_q        <= drop_d;
    end
  end

  fetch_sync_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(BUF_DEPTH)) u_pc_q (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .clr_i   (flush_i),
    .push_i  (imem_fire),
    .wdata_i (req_addr_q),
    .pop_i   (dec_fire),
    .rdata_o (pc_head),
    .count_o (pc_cnt)
  );

  fetch_sync_fifo #(.WIDTH(INSTR_WIDTH), .DEPTH(BUF_DEPTH)) u_data_q (
    .clk_i   (clock_i),
    .rst_i   (reset_i),
    .clr_i   (flush_i),
    .push_i  (data_push),
    .wdata_i (imem_rsp_data_i),
    .pop_i   (dec_fire),
    .rdata_o (data_head),
    .count_o (data_cnt)
  );

  assign instr_valid_o = (data_cnt != '0) && (pc_cnt != '0);
  assign instr_data_o  = instr_valid_o ? data_head : '0;
  assign instr_pc_o    = instr_valid_o ? pc_head   : '0;

`ifdef FETCH_STATS_EN
  logic [31:0]   stat_fetch_q, stat_drop_q;
  logic [CW-1:0] flushed_buf;

  // Entries still buffered after any same-cycle decode transfer are lost to the flush.
  assign flushed_buf = data_cnt - CW'(dec_fire);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      stat_fetch_q <= '0;
      stat_drop_q  <= '0;
    end else begin
      if (dec_fire) stat_fetch_q <= stat_fetch_q + 32'd1;
      if (flush_i)
        stat_drop_q <= stat_drop_q + 32'(flushed_buf) + 32'(imem_rsp_valid_i);
      else if (rsp_drop)
        stat_drop_q <= stat_drop_q + 32'd1;
    end
  end

  assign stat_fetch_count_o = stat_fetch_q;
  assign stat_drop_count_o  = stat_drop_q;
`endif

endmodule

// File: tb/tb_fetch_request_unit.sv
// Directed scoreboard bench for fetch_request_unit with an in-order imem responder.
module tb_fetch_request_unit;
  import fetch_request_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset, pc_valid, pc_ready, flush;
  logic [31:0] pc_addr;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetch, stat_drop;
`endif

  fetch_request_unit dut (
    .clock_i          (clk),
    .reset_i          (reset),
    .pc_valid_i       (pc_valid),
    .pc_ready_o       (pc_ready),
    .pc_addr_i        (pc_addr),
    .flush_i          (flush),
    .imem_req_valid_o (imem_req_valid),
    .imem_req_ready_i (imem_req_ready),
    .imem_req_addr_o  (imem_req_addr),
    .imem_rsp_valid_i (imem_rsp_valid),
    .imem_rsp_data_i  (imem_rsp_data),
    .instr_valid_o    (instr_valid),
    .instr_ready_i    (instr_ready),
    .instr_data_o     (instr_data),
    .instr_pc_o       (instr_pc)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetch_count_o (stat_fetch),
    .stat_drop_count_o  (stat_drop)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc = 0, dec_cnt = 0, first_dec = 0, last_dec = 0, pc_acc = 0;
  bit mem_stall = 1'b0;
  fetch_entry_t exp_q[$];
  logic [31:0]  mem_q[$];

  function automatic logic [31:0] fimg(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes at negedge, update scoreboard, then memory responds after posedge.
  task automatic tick();
    bit pf, mf, df;
    fetch_entry_t e;
    @(negedge clk);
    pf = pc_valid && pc_ready;
    mf = imem_req_valid && imem_req_ready;
    df = instr_valid && instr_ready;
    if (df) begin
      dec_cnt++;
      last_dec = cyc;
      if (dec_cnt == 1) first_dec = cyc;
      chk("exp_avail", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("instr_pc", 64'(instr_pc), 64'(e.pc));
        chk("instr_data", 64'(instr_data), 64'(e.instr));
      end
    end
    if (pf) begin
      e.pc    = pc_addr;
      e.instr = fimg(pc_addr);
      exp_q.push_back(e);
      pc_acc++;
    end
    if (mf) mem_q.push_back(imem_req_addr);
    if (flush) exp_q.delete();
    if (reset) begin
      exp_q.delete();
      mem_q.delete();
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!mem_stall && mem_q.size() != 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = fimg(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || mem_q.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    chk("drain_bound", 64'(n < 60), 64'd1);
    tick();
    tick();
  endtask

  task automatic do_reset();
    instr_ready = 1'b0;
    pc_valid    = 1'b0;
    reset       = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_pc_ready", 64'(pc_ready), 64'd0);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_req_addr", 64'(imem_req_addr), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr_data", 64'(instr_data), 64'd0);
    chk("rst_instr_pc", 64'(instr_pc), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", 64'(pc_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int d0, a0;
    reset = 1'b1; pc_valid = 1'b0; pc_addr = '0; flush = 1'b0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    instr_ready = 1'b0;

    do_reset();

    // Streaming fetch: back-to-back PCs, one instruction per cycle once filled.
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pc_valid = 1'b1;
      pc_addr  = 32'(i * 4);
      #1;
      chk("stream_pc_ready", 64'(pc_ready), 64'd1);
      tick();
    end
    pc_valid = 1'b0;
    drain();
    chk("stream_count", 64'(dec_cnt), 64'd10);
    chk("stream_b2b", 64'(last_dec - first_dec), 64'd9);

    // Two requests in flight, flushed before their responses return.
    mem_stall = 1'b1;
    pc_valid = 1'b1; pc_addr = 32'h10; tick();
    pc_addr = 32'h14; tick();
    pc_valid = 1'b0; tick();
    flush = 1'b1;
    #1;
    chk("flush_pc_ready", 64'(pc_ready), 64'd0);
    tick();
    flush = 1'b0;
    mem_stall = 1'b0;
    d0 = dec_cnt;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("flush_quiet", 64'(instr_valid), 64'd0);
      tick();
    end
    chk("flush_none_deliv", 64'(dec_cnt - d0), 64'd0);
`ifdef FETCH_STATS_EN
    chk("stat_fetch", 64'(stat_fetch), 64'd10);
    chk("stat_drop", 64'(stat_drop), 64'd2);
`endif
    pc_valid = 1'b1; pc_addr = 32'h100; tick();
    pc_valid = 1'b0;
    drain();
    chk("post_flush_deliv", 64'(dec_cnt - d0), 64'd1);

    // Decode stalled: occupancy limit caps acceptance at the buffer depth.
    instr_ready = 1'b0;
    a0 = pc_acc;
    for (int i = 0; i < 12; i++) begin
      pc_valid = 1'b1;
      pc_addr  = 32'h1000 + 32'((pc_acc - a0) * 4);
      tick();
    end
    chk("full_accepted", 64'(pc_acc - a0), 64'd4);
    #1;
    chk("full_pc_ready", 64'(pc_ready), 64'd0);
    pc_valid = 1'b0;
    instr_ready = 1'b1;
    d0 = dec_cnt;
    drain();
    chk("full_released", 64'(dec_cnt - d0), 64'd4);

    // imem backpressure: request register holds its address stable.
    imem_req_ready = 1'b0;
    pc_valid = 1'b1; pc_addr = 32'h40; tick();
    pc_addr = 32'h44;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_req_valid", 64'(imem_req_valid), 64'd1);
      chk("stall_req_addr", 64'(imem_req_addr), 64'h40);
      chk("stall_pc_ready", 64'(pc_ready), 64'd0);
      tick();
    end
    imem_req_ready = 1'b1;
    tick();
    pc_valid = 1'b0;
    drain();

    // Flush with buffered entries while decode takes the head that same cycle.
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc_valid = 1'b1; pc_addr = 32'h300 + 32'(i * 4); tick();
    end
    pc_valid = 1'b0;
    repeat (4) tick();
    #1;
    chk("buf_valid", 64'(instr_valid), 64'd1);
    d0 = dec_cnt;
    flush = 1'b1; instr_ready = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("buf_flush_quiet", 64'(instr_valid), 64'd0);
      tick();
    end
    chk("buf_flush_deliv", 64'(dec_cnt - d0), 64'd1);

    // Reset with three entries buffered, then a fresh fetch.
    for (int i = 0; i < 3; i++) begin
      pc_valid = 1'b1; pc_addr = 32'h500 + 32'(i * 4); instr_ready = 1'b0; tick();
    end
    pc_valid = 1'b0;
    repeat (4) tick();
    do_reset();
    instr_ready = 1'b1;
    d0 = dec_cnt;
    pc_valid = 1'b1; pc_addr = 32'h200; tick();
    pc_valid = 1'b0;
    drain();
    chk("reset_fresh_deliv", 64'(dec_cnt - d0), 64'd1);
`ifdef FETCH_STATS_EN
    chk("stat_fetch_after_rst", 64'(stat_fetch), 64'd1);
    chk("stat_drop_after_rst", 64'(stat_drop), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
